dot_prod_host_driver: RTL and testbench
=======================================

Name: dot_prod_host_driver

Overview: Host-side initiator for the generated dot-product core's control interface. Streams element pairs into the core's two array memories `a` and `b` through the controlArr write ports, then starts the core and waits for its completion flag. It captures the signed result and returns it on a valid/ready output channel. It sits between a testbench or host FIFO and one dot-product core instance.

Parameters:
N, 1000, element count per job (1..2^AW)
AW, 10, array address width
DW, 27, signed element width
RW, 64, signed result/accumulator width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element pair valid
in_ready  out  1  element pair accepted when in_valid&in_ready
in_a  in  DW  signed element for array a
in_b  in  DW  signed element for array b
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_result  out  RW  signed dot product
out_err  out  1  readback checksum mismatch (0 unless DRV_READBACK_EN)
busy  out  1  high in every state except LOAD with count==0
controlArr  out  1  host owns core arrays
controlArrWEnable_a / _b  out  1  array write enable
controlArrAddr_a / _b  out  AW  array address (a and b always driven identically)
controlArrWData_a / _b  out  DW  array write data
controlArrRData_a / _b  in  DW  array read data, valid one cycle after address
r_enable  out  1  core park/init; core runs while low
init_i  out  AW  constant 0
init_acc  out  RW  constant 0
w_enable  in  1  core done (registered, sticky until r_enable)
result  in  RW  core result, valid while w_enable

Behaviour:
- Reset (async, rst_n low): state=LOAD, count=0, in_ready=0, out_valid=0, out_result=0, out_err=0, controlArr=0, WEnable=0, addr=0, wdata=0, r_enable=1 (core parked). in_ready rises the first cycle after rst_n deasserts.
- States: LOAD -> (CHECK) -> RUN -> DONE -> LOAD.
- LOAD:
  - controlArr=1, r_enable=1, in_ready=1.
  - A beat accepted at edge k drives WEnable_a/_b=1, addr=count, wdata=in_a/in_b during cycle k+1. All write-port signals are registered.
  - count increments per beat.
  - Gaps in in_valid give WEnable=0 and addr held.
  - When the N-th beat is accepted, in_ready drops next cycle. After the final write cycle, go to CHECK if the macro is defined, else RUN.
- RUN:
  - controlArr=0, r_enable=0, WEnable=0, in_ready=0.
  - Wait for w_enable==1; w_enable is guaranteed 0 on entry because r_enable was high.
  - On the first cycle w_enable==1, register result into out_result and go to DONE.
  - No timeout.
- DONE:
  - r_enable=1 (re-park core), out_valid=1, out_result held stable.
  - On out_valid&out_ready: out_valid=0, count=0, out_err=0, go to LOAD.
  - in_ready stays 0 until LOAD.
- No transition consumes an input beat and emits a result in the same cycle.
- Arithmetic: out_result is forwarded unchanged from result, with no truncation. N is compared against a count of AW+1 bits, so N=2^AW is legal.
- Reset mid-operation (any state): immediate return to reset values. Array contents are not cleared, and the next job overwrites all N entries.

Optional Feature:
Macro DRV_READBACK_EN.
- Defined:
  - During LOAD, sign-extend each written a/b to RW and accumulate into sum_wa/sum_wb (mod 2^RW).
  - CHECK state: controlArr=1, WEnable=0, addr sweeps 0..N-1 one per cycle. Read data sampled one cycle after each address is accumulated into sum_ra/sum_rb.
  - After N+1 cycles, compare sums:
    - Equal: go to RUN.
    - Mismatch: set out_err=1, out_result=0, skip RUN, go to DONE.
- Not defined: no CHECK state, no sum registers, out_err tied 0, controlArrRData ignored.

Test Plan:
- N=4, beats a={1,2,3,4}, b={5,6,7,8}, core model attached -> four write cycles at addr 0..3, then r_enable falls; out_valid with out_result=70, out_err=0.
- N=4, a={-1,-2,100,0}, b={3,-4,2,7} -> out_result=205; pairs with in_valid gaps every other cycle produce the same result and addr never skips.
- out_ready held low 20 cycles after completion -> out_valid=1, out_result stable, r_enable=1, in_ready=0; out_ready pulse returns to LOAD with count=0.
- rst_n asserted after beat 2 of 4 -> same cycle controlArr=0, r_enable=1, in_ready=0; after release, a fresh 4-beat job a=b={2,2,2,2} gives out_result=16.
- DRV_READBACK_EN, bench forces a mem word to differ after write -> out_err=1, out_result=0, r_enable never falls; clean rerun gives out_err=0 and the correct result.
- N=1024 (AW=10), all a=b=1 -> out_result=1024, addresses 0..1023 each written exactly once.

Source files
------------

// File: rtl/dot_prod_host_driver_if.sv
// Host-side stream bundle of the dot-product host driver: element-pair input
// channel plus result output channel, both valid/ready.
interface dot_prod_host_driver_if #(
    parameter int DW = 27,
    parameter int RW = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a;
    logic signed [DW-1:0] in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [RW-1:0] out_result;
    logic                 out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_err
    );
endinterface

// File: rtl/dot_prod_host_driver.sv
// Host initiator for a dot-product core: loads arrays a/b, runs the core, returns the result.
// Optional DRV_READBACK_EN adds a CHECK pass that reads the arrays back and compares checksums.
module dot_prod_host_driver #(
    parameter int N  = 1000,
    parameter int AW = 10,
    parameter int DW = 27,
    parameter int RW = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dot_prod_host_driver_if.slave host,
    output logic                  busy,
    output logic                  controlArr,
    output logic                  controlArrWEnable_a,
    output logic                  controlArrWEnable_b,
    output logic [AW-1:0]         controlArrAddr_a,
    output logic [AW-1:0]         controlArrAddr_b,
    output logic [DW-1:0]         controlArrWData_a,
    output logic [DW-1:0]         controlArrWData_b,
    input  logic [DW-1:0]         controlArrRData_a,
    input  logic [DW-1:0]         controlArrRData_b,
    output logic                  r_enable,
    output logic [AW-1:0]         init_i,
    output logic [RW-1:0]         init_acc,
    input  logic                  w_enable,
    input  logic [RW-1:0]         result
);
`ifdef DRV_READBACK_EN
    typedef enum logic [1:0] {S_LOAD, S_CHECK, S_RUN, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;
`endif

    // One extra bit so that N == 2^AW is representable.
    localparam logic [AW:0] NCNT = (AW+1)'(N);

    state_t        r_state, w_next;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_in_ready, r_we, r_ctrl, r_ren, r_out_valid, r_out_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wa, r_wb;
    logic [RW-1:0] r_out_result;
    logic          w_accept, w_out_fire, w_ctrl_nxt;

    assign w_accept   = host.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & host.out_ready;
    assign w_ctrl_nxt = (w_next != S_RUN) && (w_next != S_DONE);

`ifdef DRV_READBACK_EN
    logic [RW-1:0] r_sum_wa, r_sum_wb, r_sum_ra, r_sum_rb, w_sum_ra, w_sum_rb;
    logic [AW:0]   r_ck;
    logic          w_chk_ok;

    function automatic logic [RW-1:0] sext(input logic [DW-1:0] v);
        return {{(RW-DW){v[DW-1]}}, v};
    endfunction

    // Final compare folds in the read data of address N-1, arriving in the last CHECK cycle.
    assign w_sum_ra = r_sum_ra + sext(controlArrRData_a);
    assign w_sum_rb = r_sum_rb + sext(controlArrRData_b);
    assign w_chk_ok = (w_sum_ra == r_sum_wa) && (w_sum_rb == r_sum_wb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_wa <= '0;
            r_sum_wb <= '0;
            r_sum_ra <= '0;
            r_sum_rb <= '0;
            r_ck     <= '0;
        end else if (r_state == S_LOAD && w_accept) begin
            r_sum_wa <= r_sum_wa + sext(host.in_a);
            r_sum_wb <= r_sum_wb + sext(host.in_b);
        end else if (r_state == S_CHECK) begin
            r_ck <= r_ck + 1'b1;
            if (r_ck != '0) begin
                r_sum_ra <= w_sum_ra;
                r_sum_rb <= w_sum_rb;
            end
        end else if (w_out_fire) begin
            r_sum_wa <= '0;
            r_sum_wb <= '0;
            r_sum_ra <= '0;
            r_sum_rb <= '0;
            r_ck     <= '0;
        end
    end
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^{controlArrRData_a, controlArrRData_b};
`endif

    always_comb begin
        w_next      = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_LOAD: begin
                w_count_nxt = r_count + {{AW{1'b0}}, w_accept};
                // count==N only during the final write cycle
                if (r_count == NCNT)
`ifdef DRV_READBACK_EN
                    w_next = S_CHECK;
`else
                    w_next = S_RUN;
`endif
            end
`ifdef DRV_READBACK_EN
            S_CHECK: if (r_ck == NCNT) w_next = w_chk_ok ? S_RUN : S_DONE;
`endif
            S_RUN:   if (w_enable) w_next = S_DONE;
            S_DONE: begin
                if (w_out_fire) begin
                    w_next      = S_LOAD;
                    w_count_nxt = '0;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_in_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_ctrl       <= 1'b0;
            r_ren        <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_result <= '0;
            r_addr       <= '0;
            r_wa         <= '0;
            r_wb         <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_next == S_LOAD) && (w_count_nxt < NCNT);
            r_we        <= w_accept;
            r_ctrl      <= w_ctrl_nxt;
            r_ren       <= (w_next != S_RUN);
            r_out_valid <= (w_next == S_DONE);
            if (w_accept) begin
                r_addr <= r_count[AW-1:0];
                r_wa   <= host.in_a;
                r_wb   <= host.in_b;
            end
`ifdef DRV_READBACK_EN
            else if (w_next == S_CHECK) begin
                r_addr <= (r_state == S_CHECK) ? r_addr + 1'b1 : '0;
            end
            if (r_state == S_CHECK && w_next == S_DONE) begin
                r_out_err    <= 1'b1;
                r_out_result <= '0;
            end
`endif
            if (r_state == S_RUN && w_enable) r_out_result <= result;
            if (w_out_fire) r_out_err <= 1'b0;
        end
    end

    assign host.in_ready       = r_in_ready;
    assign host.out_valid      = r_out_valid;
    assign host.out_result     = r_out_result;
    assign host.out_err        = r_out_err;
    assign busy                = !(r_state == S_LOAD && r_count == '0);
    assign controlArr          = r_ctrl;
    assign controlArrWEnable_a = r_we;
    assign controlArrWEnable_b = r_we;
    assign controlArrAddr_a    = r_addr;
    assign controlArrAddr_b    = r_addr;
    assign controlArrWData_a   = r_wa;
    assign controlArrWData_b   = r_wb;
    assign r_enable            = r_ren;
    assign init_i              = '0;
    assign init_acc            = '0;
endmodule

// File: tb/tb_dot_prod_host_driver.sv
// Bench for dot_prod_host_driver: a 4-element instance and a 1024-element instance,
// each with a behavioural array memory and core, checked against a plain dot-product model.
module tb_dot_prod_host_driver;
    localparam int DW = 27, RW = 64, N0 = 4, AW0 = 2, N1 = 1024, AW1 = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    dot_prod_host_driver_if #(.DW(DW), .RW(RW)) h0 ();
    dot_prod_host_driver_if #(.DW(DW), .RW(RW)) h1 ();

    logic           busy0, c0_ctrl, c0_wea, c0_web, c0_ren, c0_wen = 1'b0;
    logic [AW0-1:0] c0_aa, c0_ab, c0_ii;
    logic [DW-1:0]  c0_wda, c0_wdb, c0_rda, c0_rdb;
    logic [RW-1:0]  c0_ia, c0_res;

    logic           busy1, c1_ctrl, c1_wea, c1_web, c1_ren, c1_wen = 1'b0;
    logic [AW1-1:0] c1_aa, c1_ab, c1_ii;
    logic [DW-1:0]  c1_wda, c1_wdb, c1_rda, c1_rdb;
    logic [RW-1:0]  c1_ia, c1_res;

    dot_prod_host_driver #(.N(N0), .AW(AW0), .DW(DW), .RW(RW)) u0 (
        .clk(clk), .rst_n(rst_n), .host(h0), .busy(busy0), .controlArr(c0_ctrl),
        .controlArrWEnable_a(c0_wea), .controlArrWEnable_b(c0_web),
        .controlArrAddr_a(c0_aa), .controlArrAddr_b(c0_ab),
        .controlArrWData_a(c0_wda), .controlArrWData_b(c0_wdb),
        .controlArrRData_a(c0_rda), .controlArrRData_b(c0_rdb),
        .r_enable(c0_ren), .init_i(c0_ii), .init_acc(c0_ia),
        .w_enable(c0_wen), .result(c0_res));

    dot_prod_host_driver #(.N(N1), .AW(AW1), .DW(DW), .RW(RW)) u1 (
        .clk(clk), .rst_n(rst_n), .host(h1), .busy(busy1), .controlArr(c1_ctrl),
        .controlArrWEnable_a(c1_wea), .controlArrWEnable_b(c1_web),
        .controlArrAddr_a(c1_aa), .controlArrAddr_b(c1_ab),
        .controlArrWData_a(c1_wda), .controlArrWData_b(c1_wdb),
        .controlArrRData_a(c1_rda), .controlArrRData_b(c1_rdb),
        .r_enable(c1_ren), .init_i(c1_ii), .init_acc(c1_ia),
        .w_enable(c1_wen), .result(c1_res));

    // Behavioural arrays and core: result appears a few cycles after r_enable falls.
    logic signed [DW-1:0] m0a [N0];
    logic signed [DW-1:0] m0b [N0];
    logic signed [DW-1:0] m1a [N1];
    logic signed [DW-1:0] m1b [N1];
    logic [AW0-1:0] wlog0 [$];
    int  wcnt1 [N1];
    int  run_cyc0 = 0, cyc0 = 0, cyc1 = 0;
    bit  corrupt0 = 1'b0;

    function automatic longint dot0();
        longint acc = 0;
        for (int j = 0; j < N0; j++) acc += longint'(m0a[j]) * longint'(m0b[j]);
        return acc;
    endfunction

    function automatic longint dot1();
        longint acc = 0;
        for (int j = 0; j < N1; j++) acc += longint'(m1a[j]) * longint'(m1b[j]);
        return acc;
    endfunction

    always @(posedge clk) begin
        if (c0_ctrl && c0_wea) begin
            m0a[c0_aa] <= c0_wda;
            wlog0.push_back(c0_aa);
        end
        if (c0_ctrl && c0_web) m0b[c0_ab] <= c0_wdb;
        if (corrupt0) m0a[N0-1] <= m0a[N0-1] ^ 1;
        c0_rda <= m0a[c0_aa];
        c0_rdb <= m0b[c0_ab];
        if (c0_ren) begin
            c0_wen <= 1'b0;
            cyc0   <= 0;
        end else begin
            run_cyc0 <= run_cyc0 + 1;
            if (!c0_wen) begin
                cyc0 <= cyc0 + 1;
                if (cyc0 == 3) begin
                    c0_res <= dot0();
                    c0_wen <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (c1_ctrl && c1_wea) begin
            m1a[c1_aa] <= c1_wda;
            wcnt1[c1_aa] <= wcnt1[c1_aa] + 1;
        end
        if (c1_ctrl && c1_web) m1b[c1_ab] <= c1_wdb;
        c1_rda <= m1a[c1_aa];
        c1_rdb <= m1b[c1_ab];
        if (c1_ren) begin
            c1_wen <= 1'b0;
            cyc1   <= 0;
        end else if (!c1_wen) begin
            cyc1 <= cyc1 + 1;
            if (cyc1 == 3) begin
                c1_res <= dot1();
                c1_wen <= 1'b1;
            end
        end
    end

    // Reference model: job element lists and their plain dot product.
    int ja [N0];
    int jb [N0];

    function automatic longint ref0();
        longint acc = 0;
        for (int i = 0; i < N0; i++) acc += longint'(ja[i]) * longint'(jb[i]);
        return acc;
    endfunction

    function automatic int rnd_elem();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return int'(t);
    endfunction

    // mode 0: back-to-back, 1: gap every other cycle, 2: random gaps
    task automatic send_job0(input int mode, input int nbeats);
        int  i = 0, guard = 0;
        bit  gap_next = 1'b0;
        while (i < nbeats) begin
            @(negedge clk);
            if ((mode == 1 && gap_next) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                h0.in_valid = 1'b0;
                gap_next    = 1'b0;
            end else begin
                h0.in_valid = 1'b1;
                h0.in_a     = DW'(ja[i]);
                h0.in_b     = DW'(jb[i]);
                if (h0.in_ready) i++;
                gap_next = 1'b1;
            end
            guard++;
            if (guard > 200) begin
                total++; bad++;
                $display("FAIL send0: accepted %0d beats, required %0d", i, nbeats);
                break;
            end
        end
        @(negedge clk);
        h0.in_valid = 1'b0;
    endtask

    task automatic wait_out0(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (h0.out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait0: out_valid never rose, required 1");
        end
    endtask

    task automatic release0(input string nm);
        @(negedge clk);
        h0.out_ready = 1'b1;
        @(negedge clk);
        h0.out_ready = 1'b0;
        total++;
        if (h0.out_valid !== 1'b0 || busy0 !== 1'b0 || h0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1",
                     nm, h0.out_valid, busy0, h0.in_ready);
        end
    endtask

    task automatic do_job0(input int mode, input string nm);
        int     wl = wlog0.size();
        int     rc = run_cyc0;
        longint exp_r = ref0();
        bit     ok, addr_ok;
        send_job0(mode, N0);
        wait_out0(ok);
        if (ok) begin
            total++;
            if (h0.out_result !== exp_r || h0.out_err !== 1'b0) begin
                bad++;
                $display("FAIL %s result: got %0d err=%0b required %0d err=0",
                         nm, h0.out_result, h0.out_err, exp_r);
            end
            total++;
            if (run_cyc0 == rc) begin
                bad++;
                $display("FAIL %s run: r_enable never fell, required a run phase", nm);
            end
            addr_ok = (wlog0.size() - wl == N0);
            for (int k = 0; k < N0 && addr_ok; k++)
                if (wlog0[wl+k] !== AW0'(k)) addr_ok = 1'b0;
            total++;
            if (!addr_ok) begin
                bad++;
                $display("FAIL %s addr: %0d writes logged, required %0d at ascending addresses",
                         nm, wlog0.size() - wl, N0);
            end
            release0(nm);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if (h0.in_ready !== 1'b0 || h0.out_valid !== 1'b0 || h0.out_result !== '0 ||
            h0.out_err !== 1'b0 || c0_ctrl !== 1'b0 || c0_wea !== 1'b0 || c0_aa !== '0 ||
            c0_wda !== '0 || c0_ren !== 1'b1 || busy0 !== 1'b0 || c1_ren !== 1'b1) begin
            bad++;
            $display("FAIL reset: in_ready=%0b out_valid=%0b ctrl=%0b we=%0b r_enable=%0b busy=%0b",
                     h0.in_ready, h0.out_valid, c0_ctrl, c0_wea, c0_ren, busy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (h0.in_ready !== 1'b1 || c0_ctrl !== 1'b1 || c0_ren !== 1'b1) begin
            bad++;
            $display("FAIL reset_exit: in_ready=%0b ctrl=%0b r_enable=%0b required 1 1 1",
                     h0.in_ready, c0_ctrl, c0_ren);
        end
    endtask

    task automatic test_basic();
        ja = '{1, 2, 3, 4};
        jb = '{5, 6, 7, 8};
        do_job0(0, "basic");
    endtask

    task automatic test_signed_gaps();
        ja = '{-1, -2, 100, 0};
        jb = '{3, -4, 2, 7};
        do_job0(0, "signed");
        do_job0(1, "signed_gaps");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N0; i++) begin
                ja[i] = rnd_elem();
                jb[i] = rnd_elem();
            end
            do_job0(2, "random");
        end
    endtask

    task automatic test_hold();
        longint exp_r;
        bit     ok, stable = 1'b1;
        for (int i = 0; i < N0; i++) begin
            ja[i] = rnd_elem();
            jb[i] = rnd_elem();
        end
        exp_r = ref0();
        send_job0(0, N0);
        wait_out0(ok);
        if (ok) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (h0.out_valid !== 1'b1 || h0.out_result !== exp_r ||
                    c0_ren !== 1'b1 || h0.in_ready !== 1'b0) stable = 1'b0;
            end
            total++;
            if (!stable) begin
                bad++;
                $display("FAIL hold: out_valid=%0b result=%0d r_enable=%0b in_ready=%0b required 1 %0d 1 0",
                         h0.out_valid, h0.out_result, c0_ren, h0.in_ready, exp_r);
            end
            release0("hold");
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < N0; i++) begin
            ja[i] = rnd_elem();
            jb[i] = rnd_elem();
        end
        send_job0(0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (c0_ctrl !== 1'b0 || c0_ren !== 1'b1 || h0.in_ready !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL midreset: ctrl=%0b r_enable=%0b in_ready=%0b busy=%0b required 0 1 0 0",
                     c0_ctrl, c0_ren, h0.in_ready, busy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ja = '{2, 2, 2, 2};
        jb = '{2, 2, 2, 2};
        do_job0(0, "after_reset");
    endtask

    task automatic test_readback();
`ifdef DRV_READBACK_EN
        int rc;
        bit ok;
        for (int i = 0; i < N0; i++) begin
            ja[i] = rnd_elem();
            jb[i] = rnd_elem();
        end
        rc = run_cyc0;
        send_job0(0, N0);
        @(negedge clk);
        corrupt0 = 1'b1;
        @(negedge clk);
        corrupt0 = 1'b0;
        wait_out0(ok);
        if (ok) begin
            total++;
            if (h0.out_err !== 1'b1 || h0.out_result !== '0 || run_cyc0 != rc) begin
                bad++;
                $display("FAIL readback: err=%0b result=%0d run_cycles=%0d required 1 0 0",
                         h0.out_err, h0.out_result, run_cyc0 - rc);
            end
            release0("readback");
        end
        do_job0(0, "readback_clean");
`endif
    endtask

    task automatic test_big();
        int  i = 0, guard = 0, once = 0;
        bit  ok = 1'b0;
        while (i < N1 && guard < 4000) begin
            @(negedge clk);
            h1.in_valid = 1'b1;
            h1.in_a     = DW'(1);
            h1.in_b     = DW'(1);
            if (h1.in_ready) i++;
            guard++;
        end
        @(negedge clk);
        h1.in_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (h1.out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok || h1.out_result !== 64'd1024 || h1.out_err !== 1'b0) begin
            bad++;
            $display("FAIL big result: valid=%0b got %0d err=%0b required 1024 err=0",
                     ok, h1.out_result, h1.out_err);
        end
        for (int k = 0; k < N1; k++) if (wcnt1[k] == 1) once++;
        total++;
        if (once != N1) begin
            bad++;
            $display("FAIL big addr: %0d addresses written once, required %0d", once, N1);
        end
        @(negedge clk);
        h1.out_ready = 1'b1;
        @(negedge clk);
        h1.out_ready = 1'b0;
        total++;
        if (h1.out_valid !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL big release: out_valid=%0b busy=%0b required 0 0", h1.out_valid, busy1);
        end
    endtask

    initial begin
        h0.in_valid = 1'b0; h0.in_a = '0; h0.in_b = '0; h0.out_ready = 1'b0;
        h1.in_valid = 1'b0; h1.in_a = '0; h1.in_b = '0; h1.out_ready = 1'b0;
        for (int k = 0; k < N1; k++) wcnt1[k] = 0;
        test_reset();
        test_basic();
        test_signed_gaps();
        test_random();
        test_hold();
        test_midreset();
        test_readback();
        test_big();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
